// File: rtl/div_unit.sv
// Iterative restoring divider: {hi=remainder, lo=quotient}, ready_o WIDTH+1 cycles after start (2 for b==0).
// No backpressure: stall_o holds the E stage until the DONE cycle; annul_i flushes at any time.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic               annul_i,
  output logic               stall_o,
  output logic               ready_o,
  output logic [2*WIDTH-1:0] result_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]    LAST  = CW'(WIDTH - 1);
  localparam logic [CW-1:0]    CNT1  = CW'(1);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  typedef enum logic [1:0] {IDLE, ON, DIVZERO, DONE} state_t;

  state_t               state_q;
  logic [CW-1:0]        cnt_q;
  logic [WIDTH-1:0]     rem_q, quo_q, dvs_q;
  logic                 qneg_q, rneg_q;
  logic                 ready_q;
  logic [2*WIDTH-1:0]   result_q;

  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       trial;
  logic [WIDTH-1:0]     rem_d, quo_d;
  logic [WIDTH-1:0]     q_fix, r_fix;

  // Magnitudes are unsigned WIDTH bits, so the most negative value maps to 2^(WIDTH-1).
  assign a_mag = (signed_i && a_i[WIDTH-1]) ? (~a_i + ONE) : a_i;
  assign b_mag = (signed_i && b_i[WIDTH-1]) ? (~b_i + ONE) : b_i;

  always_comb begin
    trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
    rem_d = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
    quo_d = {quo_q[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH]) begin
      rem_d = trial[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b1};
    end
    q_fix = qneg_q ? (~quo_d + ONE) : quo_d;
    r_fix = rneg_q ? (~rem_d + ONE) : rem_d;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      ready_q  <= 1'b0;
      result_q <= '0;
    end else if (annul_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            rem_q   <= '0;
            quo_q   <= a_mag;
            dvs_q   <= b_mag;
            qneg_q  <= signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
            rneg_q  <= signed_i & a_i[WIDTH-1];
            cnt_q   <= '0;
            state_q <= (b_i == '0) ? DIVZERO : ON;
          end
        end
        ON: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + CNT1;
          if (cnt_q == LAST) begin
            state_q  <= DONE;
            ready_q  <= 1'b1;
            result_q <= {r_fix, q_fix};
          end
        end
        DIVZERO: begin
          state_q  <= DONE;
          ready_q  <= 1'b1;
          result_q <= '0;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stall_o  = start_i & (state_q != DONE);
  assign ready_o  = ready_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit with a queue scoreboard checked on ready_o.
module tb_div_unit;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          resetn;
  logic          start_i, signed_i, annul_i;
  logic [W-1:0]  a_i, b_i;
  logic          stall_o, ready_o;
  logic [2*W-1:0] result_o;

  typedef struct {
    logic [2*W-1:0] res;
    int             cyc;
  } exp_t;

  exp_t           sb_q[$];
  int             cyc = 0;
  int             total = 0;
  int             bad = 0;
  logic [2*W-1:0] last_res;

  div_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .start_i  (start_i),
    .signed_i (signed_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .annul_i  (annul_i),
    .stall_o  (stall_o),
    .ready_o  (ready_o),
    .result_o (result_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [2*W-1:0] act, input logic [2*W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Monitor: every ready_o pulse must match the oldest expected entry, in value and cycle.
  always @(negedge clk) begin
    if (resetn && ready_o) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ready actual=1 required=0 at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("result", result_o, e.res);
        chk("ready_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic run_div(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2*W-1:0] req, input int lat);
    int n;
    @(negedge clk);
    start_i  = 1'b1;
    signed_i = sgn;
    a_i      = a;
    b_i      = b;
    sb_q.push_back('{res: req, cyc: cyc + lat});
    last_res = req;
    n = 0;
    #1;
    while (stall_o && n < 200) begin
      n++;
      @(negedge clk);
      a_i      = $urandom;
      b_i      = $urandom;
      signed_i = ~signed_i;
      #1;
    end
    chk("stall_cycles", 64'(n), 64'(lat));
    start_i = 1'b0;
  endtask

  task automatic quiet_hold(input int ncyc);
    repeat (ncyc) @(negedge clk);
    #1;
    chk("result_hold", result_o, last_res);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn   = 1'b0;
    start_i  = 1'b0;
    signed_i = 1'b0;
    annul_i  = 1'b0;
    a_i      = '0;
    b_i      = '0;
    last_res = '0;
    #1;
    chk("reset_result", result_o, 64'h0);
    chk("reset_ready", 64'(ready_o), 64'h0);
    chk("reset_stall_lo", 64'(stall_o), 64'h0);
    start_i = 1'b1;
    #1;
    chk("reset_stall_hi", 64'(stall_o), 64'h1);
    start_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;

    run_div(1'b0, 32'd100,        32'd7,        {32'd2,        32'd14},        33);
    run_div(1'b1, 32'hFFFFFFF9,   32'd2,        {32'hFFFFFFFF, 32'hFFFFFFFD},  33);
    run_div(1'b1, 32'h80000000,   32'hFFFFFFFF, {32'h0,        32'h80000000},  33);
    run_div(1'b0, 32'h80000000,   32'hFFFFFFFF, {32'h80000000, 32'h0},         33);
    run_div(1'b0, 32'd1234,       32'd0,        64'h0,                         2);
    run_div(1'b1, 32'd7,          32'hFFFFFFFE, {32'd1,        32'hFFFFFFFD},  33);
    run_div(1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9, {32'hFFFFFFFE, 32'd14},        33);
    run_div(1'b1, 32'hFFFFFFF9,   32'd0,        64'h0,                         2);
    run_div(1'b0, 32'hFFFFFFFF,   32'd1,        {32'd0,        32'hFFFFFFFF},  33);
    run_div(1'b0, 32'd5,          32'd10,       {32'd5,        32'd0},         33);

    // Annul in ON step 10: no pulse, result untouched, then a fresh divide.
    @(negedge clk);
    start_i  = 1'b1;
    signed_i = 1'b0;
    a_i      = 32'd5000;
    b_i      = 32'd3;
    repeat (11) @(negedge clk);
    annul_i = 1'b1;
    @(negedge clk);
    annul_i = 1'b0;
    start_i = 1'b0;
    #1;
    chk("annul_result", result_o, last_res);
    quiet_hold(40);
    run_div(1'b0, 32'd1000,       32'd33,       {32'd10,       32'd30},        33);

    // Reset mid-ON: outputs clear at once, no late pulse.
    @(negedge clk);
    start_i  = 1'b1;
    signed_i = 1'b0;
    a_i      = 32'd2000;
    b_i      = 32'd7;
    repeat (12) @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    chk("midreset_result", result_o, 64'h0);
    chk("midreset_ready", 64'(ready_o), 64'h0);
    chk("midreset_stall", 64'(stall_o), 64'h1);
    start_i  = 1'b0;
    last_res = '0;
    @(negedge clk);
    resetn = 1'b1;
    quiet_hold(40);
    run_div(1'b0, 32'd9,          32'd3,        {32'd0,        32'd3},         33);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 64'(sb_q.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
